// File: rtl/stack_mem_pkg.sv
// stack_mem_pkg: constants shared by the stack CPU memory responder and the
// CPU itself. It holds the MMIO register addresses, the STAT bit positions, the
// CPU reset/stack constants and the address-window select type.
package stack_mem_pkg;

    // MMIO register block: four consecutive words at 0x8000.
    localparam logic [15:0] ADDR_TXD   = 16'h8000;
    localparam logic [15:0] ADDR_STAT  = 16'h8001;
    localparam logic [15:0] ADDR_CYCLO = 16'h8002;
    localparam logic [15:0] ADDR_CYCHI = 16'h8003;

    // STAT register bit positions. The FIFO count is in bits [15:8].
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_OVF   = 2;
    localparam int STAT_ERR   = 3;

    // Constants shared with the CPU.
    localparam logic [15:0] STACK_START_POINT = 16'hFFFF;
    localparam logic [15:0] ENTRY_POINT       = 16'h0020;

    // Identifies which window an address decodes to.
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_LOW,
        SEL_STK,
        SEL_MMIO
    } mem_sel_e;

endpackage

// File: rtl/stack_mem_responder_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
//   clk, rst_n   : clock and synchronous active-low reset
//   push, wdata  : write request and data. The word is dropped when the FIFO
//                  is full, unless a pop happens in the same cycle.
//   pop          : read request. It is ignored when the FIFO is empty.
//   rdata        : head word. It is only meaningful when empty is low.
//   full, empty  : occupancy flags
//   count        : number of stored words, 0..DEPTH
import stack_mem_pkg::*;

module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    // A pop on a full FIFO frees the slot that the push uses. A pop on an
    // empty FIFO does nothing, so the pushed word is stored and not bypassed.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The storage array is not reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/stack_mem_responder.sv
// stack_mem_responder: memory-side responder for the 16-bit stack CPU bus.
// It backs a low RAM window at 0x0000, a stack RAM window ending at 0xFFFF,
// and an MMIO block at 0x8000-0x8003. The MMIO block holds the console TX
// FIFO, the STAT register and a 32-bit cycle counter.
//   clk, rst_n         : clock and synchronous active-low reset
//   addr, wdata, we    : CPU address, write data and write strobe. Every cycle
//                        with we=0 is a read.
//   rdata              : registered read data, with a latency of 1 cycle
//   mem_error          : registered pulse on an unmapped access
//   tx_data/valid/ready: console FIFO head with a valid/ready handshake
// Build option STACK_MEM_ERR_EN: unmapped accesses pulse mem_error and set
// STAT.ERR. When the option is undefined, both read 0.
import stack_mem_pkg::*;

module stack_mem_responder #(
    parameter int LOW_WORDS  = 1024,
    parameter int STK_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        we,
    output logic [15:0] rdata,
    output logic        mem_error,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int LAW = $clog2(LOW_WORDS);
    localparam int SAW = $clog2(STK_WORDS);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] STK_BASE = 16'(32'h10000 - STK_WORDS);

    logic [15:0] low_mem [LOW_WORDS];
    logic [15:0] stk_mem [STK_WORDS];

    mem_sel_e    sel;
    logic [LAW-1:0] low_idx;
    logic [SAW-1:0] stk_idx;
    logic        mmio_wr, push, pop;
    logic [15:0] fifo_head, stat, rd_val;
    logic        fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    logic [15:0] rdata_q, rdata_d;
    logic        mem_error_q, mem_error_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic [31:0] cyc_q, cyc_d;
    logic [15:0] shadow_q, shadow_d;

    always_comb begin
        sel = SEL_NONE;
        if ({16'h0, addr} < 32'(LOW_WORDS))            sel = SEL_LOW;
        else if (addr >= STK_BASE)                     sel = SEL_STK;
        else if (addr[15:2] == ADDR_TXD[15:2])         sel = SEL_MMIO;
    end

    assign low_idx = LAW'(addr);
    assign stk_idx = SAW'(addr - STK_BASE);
    assign mmio_wr = we && (sel == SEL_MMIO);
    assign push    = mmio_wr && (addr[1:0] == ADDR_TXD[1:0]);
    assign pop     = tx_valid && tx_ready;

    sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_valid  = !fifo_empty;
    assign tx_data   = fifo_empty ? 16'h0 : fifo_head;
    assign rdata     = rdata_q;
    assign mem_error = mem_error_q;

    always_comb begin
        stat             = '0;
        stat[15:8]       = 8'(fifo_count);
        stat[STAT_FULL]  = fifo_full;
        stat[STAT_EMPTY] = fifo_empty;
        stat[STAT_OVF]   = ovf_q;
        stat[STAT_ERR]   = err_q;
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_LOW:  rd_val = low_mem[low_idx];
            SEL_STK:  rd_val = stk_mem[stk_idx];
            SEL_MMIO: begin
                case (addr[1:0])
                    2'd0:    rd_val = tx_data;
                    2'd1:    rd_val = stat;
                    2'd2:    rd_val = cyc_q[15:0];
                    default: rd_val = shadow_q;
                endcase
            end
            default:  rd_val = '0;
        endcase
    end

    always_comb begin
        // A write cycle leaves rdata untouched.
        rdata_d  = we ? rdata_q : rd_val;
        // A CYCLO read snapshots the high half so the next CYCHI read matches it.
        shadow_d = (!we && sel == SEL_MMIO && addr[1:0] == ADDR_CYCLO[1:0])
                   ? cyc_q[31:16] : shadow_q;
        cyc_d    = (mmio_wr && addr[1]) ? 32'h0 : cyc_q + 32'h1;

        ovf_d = ovf_q;
        if (mmio_wr && addr[1:0] == ADDR_STAT[1:0]) ovf_d = 1'b0;
        else if (push && fifo_full && !pop)         ovf_d = 1'b1;

`ifdef STACK_MEM_ERR_EN
        mem_error_d = (sel == SEL_NONE);
        err_d       = err_q;
        if (mmio_wr && addr[1:0] == ADDR_STAT[1:0]) err_d = 1'b0;
        else if (sel == SEL_NONE)                   err_d = 1'b1;
`else
        mem_error_d = 1'b0;
        err_d       = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q     <= '0;
            mem_error_q <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            cyc_q       <= '0;
            shadow_q    <= '0;
        end else begin
            rdata_q     <= rdata_d;
            mem_error_q <= mem_error_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            cyc_q       <= cyc_d;
            shadow_q    <= shadow_d;
        end
    end

    // The RAM windows are not reset.
    always_ff @(posedge clk) begin
        if (we && sel == SEL_LOW) low_mem[low_idx] <= wdata;
        if (we && sel == SEL_STK) stk_mem[stk_idx] <= wdata;
    end

endmodule
